// File: rtl/output_memory_writer.sv
// Result-tile writer: takes a C tile base/stride, captures an NxN tile,
// and streams it to output memory as P-element row-major beats.
module output_memory_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int N = 4,
  parameter int MULTIPLY_DATA_WIDTH = 2*DATA_WIDTH,
  parameter int ACCUM_DATA_WIDTH = 16,
  parameter int OUT_WIDTH =
    MULTIPLY_DATA_WIDTH+ACCUM_DATA_WIDTH,
  parameter int MAX_MATRIX_LENGTH = 4096,
  parameter int STRIDE_BITS = $clog2(MAX_MATRIX_LENGTH+1),
  parameter int MEMORY_ADDRESS_BITS = 64,
  parameter int PARALLEL_DATA_STREAMING_SIZE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic instruction_valid,
  output logic instruction_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0] address_input,
  input  logic [STRIDE_BITS-1:0] stride_input,
  input  logic result_valid,
  output logic result_ready,
  input  logic [N-1:0][N-1:0][OUT_WIDTH-1:0] result_data,
  output logic memory_write_valid,
  input  logic memory_write_ready,
  output logic [MEMORY_ADDRESS_BITS-1:0] memory_write_address,
  output logic [PARALLEL_DATA_STREAMING_SIZE-1:0][OUT_WIDTH-1:0]
    memory_write_bus,
  output logic tile_done
);

  localparam int P = PARALLEL_DATA_STREAMING_SIZE;
  localparam int CHUNKS = N / P;
  localparam int AW = MEMORY_ADDRESS_BITS;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CLW = RW;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  if (N % PARALLEL_DATA_STREAMING_SIZE != 0) begin : g_bad_p
    $error("N must be a multiple of PARALLEL_DATA_STREAMING_SIZE");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    WRITE
  } state_e;

  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [STRIDE_BITS-1:0] stride_q, stride_d;
  logic [N-1:0][N-1:0][OUT_WIDTH-1:0] tile_q, tile_d;
  logic done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      chunk_q    <= '0;
      row_base_q <= '0;
      stride_q   <= '0;
      tile_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      chunk_q    <= chunk_d;
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      tile_q     <= tile_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    chunk_d    = chunk_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    tile_d     = tile_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (instruction_valid) begin
          row_base_d = address_input;
          stride_d   = stride_input;
          row_d      = '0;
          chunk_d    = '0;
          state_d    = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (result_valid) begin
          tile_d  = result_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (memory_write_ready) begin
          if (chunk_q == CW'(CHUNKS-1)) begin
            // row advance by accumulation, no multiplier
            chunk_d    = '0;
            row_d      = row_q + 1'b1;
            row_base_d = row_base_q + AW'(stride_q);
            if (row_q == RW'(N-1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign instruction_ready  = (state_q == IDLE);
  assign result_ready       = (state_q == WAIT_DATA);
  assign memory_write_valid = (state_q == WRITE);
  assign tile_done          = done_q;

  assign memory_write_address =
    row_base_q + AW'(chunk_q) * AW'(P);

  always_comb begin
    for (int p = 0; p < P; p++) begin
      memory_write_bus[p] =
        tile_q[row_q][CLW'(int'(chunk_q) * P + p)];
    end
  end

endmodule

// File: tb/tb_output_memory_writer.sv
// Scoreboard bench for output_memory_writer: P=4 main instance
// plus a P=2 instance for narrow-beat ordering.
module tb_output_memory_writer;

  typedef logic [3:0][3:0][31:0] tile_t;
  typedef struct packed {
    logic [63:0] addr;
    logic [3:0][31:0] data;
  } beat_t;

  logic clk;
  logic reset;
  logic instruction_valid;
  logic instruction_ready;
  logic [63:0] address_input;
  logic [12:0] stride_input;
  logic result_valid;
  logic result_ready;
  tile_t result_data;
  logic memory_write_valid;
  logic memory_write_ready;
  logic [63:0] memory_write_address;
  logic [3:0][31:0] memory_write_bus;
  logic tile_done;

  logic b_iv, b_ir, b_rv, b_rr, b_mv, b_mr, b_done;
  logic [63:0] b_addr_in, b_maddr;
  logic [12:0] b_stride;
  tile_t b_rdata;
  logic [1:0][31:0] b_bus;

  int n_cmp;
  int n_bad;
  beat_t exp_q[$];

  output_memory_writer dut (
    .clk(clk),
    .reset(reset),
    .instruction_valid(instruction_valid),
    .instruction_ready(instruction_ready),
    .address_input(address_input),
    .stride_input(stride_input),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_data(result_data),
    .memory_write_valid(memory_write_valid),
    .memory_write_ready(memory_write_ready),
    .memory_write_address(memory_write_address),
    .memory_write_bus(memory_write_bus),
    .tile_done(tile_done)
  );

  output_memory_writer #(.PARALLEL_DATA_STREAMING_SIZE(2)) dut_p2 (
    .clk(clk),
    .reset(reset),
    .instruction_valid(b_iv),
    .instruction_ready(b_ir),
    .address_input(b_addr_in),
    .stride_input(b_stride),
    .result_valid(b_rv),
    .result_ready(b_rr),
    .result_data(b_rdata),
    .memory_write_valid(b_mv),
    .memory_write_ready(b_mr),
    .memory_write_address(b_maddr),
    .memory_write_bus(b_bus),
    .tile_done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tile_t mk_tile(int off);
    tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = 32'(4*r + c + 1 + off);
    return t;
  endfunction

  function automatic void push_tile(logic [63:0] base,
                                    logic [63:0] stride,
                                    tile_t t, int pp);
    beat_t b;
    for (int r = 0; r < 4; r++)
      for (int ch = 0; ch < 4/pp; ch++) begin
        b.addr = base + 64'(r) * stride + 64'(ch*pp);
        b.data = '0;
        for (int p = 0; p < pp; p++) b.data[p] = t[r][ch*pp+p];
        exp_q.push_back(b);
      end
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    #2;
    n_cmp++; if (instruction_ready !== 1'b1) begin n_bad++; $display("FAIL rst_iready got %b want 1", instruction_ready); end
    n_cmp++; if (result_ready !== 1'b0) begin n_bad++; $display("FAIL rst_rready got %b want 0", result_ready); end
    n_cmp++; if (memory_write_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mvalid got %b want 0", memory_write_valid); end
    n_cmp++; if (tile_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", tile_done); end
    tick();
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (instruction_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_iready got %b want 1", instruction_ready); end
  endtask

  task automatic test_basic();
    tile_t t;
    beat_t b;
    t = mk_tile(0);
    push_tile(64'd100, 64'd8, t, 4);
    address_input = 64'd100;
    stride_input = 13'd8;
    result_data = t;
    result_valid = 1'b1;
    memory_write_ready = 1'b1;
    instruction_valid = 1'b1;
    n_cmp++; if (instruction_ready !== 1'b1) begin n_bad++; $display("FAIL basic_iready got %b want 1", instruction_ready); end
    tick();
    instruction_valid = 1'b0;
    n_cmp++; if (result_ready !== 1'b1) begin n_bad++; $display("FAIL basic_rready got %b want 1", result_ready); end
    n_cmp++; if (memory_write_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_mv got %b want 0", memory_write_valid); end
    tick();
    result_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b = exp_q.pop_front();
      n_cmp++; if (memory_write_valid !== 1'b1) begin n_bad++; $display("FAIL basic_mv%0d got %b want 1", k, memory_write_valid); end
      n_cmp++; if (memory_write_address !== b.addr) begin n_bad++; $display("FAIL basic_addr%0d got %0d want %0d", k, memory_write_address, b.addr); end
      n_cmp++; if (memory_write_bus !== b.data) begin n_bad++; $display("FAIL basic_bus%0d got %h want %h", k, memory_write_bus, b.data); end
      n_cmp++; if (tile_done !== 1'b0) begin n_bad++; $display("FAIL basic_early_done%0d got %b want 0", k, tile_done); end
      tick();
    end
    n_cmp++; if (tile_done !== 1'b1) begin n_bad++; $display("FAIL basic_done got %b want 1", tile_done); end
    n_cmp++; if (instruction_ready !== 1'b1) begin n_bad++; $display("FAIL basic_iready_end got %b want 1", instruction_ready); end
    n_cmp++; if (memory_write_valid !== 1'b0) begin n_bad++; $display("FAIL basic_mv_end got %b want 0", memory_write_valid); end
    tick();
    n_cmp++; if (tile_done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", tile_done); end
  endtask

  task automatic test_backpressure();
    tile_t t;
    int beats, stall, cyc;
    t = mk_tile(0);
    push_tile(64'd100, 64'd8, t, 4);
    address_input = 64'd100;
    stride_input = 13'd8;
    result_data = t;
    result_valid = 1'b1;
    instruction_valid = 1'b1;
    tick();
    instruction_valid = 1'b0;
    tick();
    result_valid = 1'b0;
    beats = 0;
    stall = 0;
    cyc = 0;
    while (beats < 4 && cyc < 30) begin
      memory_write_ready = !(beats == 1 && stall < 3);
      n_cmp++; if (memory_write_valid !== 1'b1) begin n_bad++; $display("FAIL bp_mv c%0d got %b want 1", cyc, memory_write_valid); end
      n_cmp++; if (memory_write_address !== exp_q[0].addr) begin n_bad++; $display("FAIL bp_addr c%0d got %0d want %0d", cyc, memory_write_address, exp_q[0].addr); end
      n_cmp++; if (memory_write_bus !== exp_q[0].data) begin n_bad++; $display("FAIL bp_bus c%0d got %h want %h", cyc, memory_write_bus, exp_q[0].data); end
      n_cmp++; if (tile_done !== 1'b0) begin n_bad++; $display("FAIL bp_early_done c%0d got %b want 0", cyc, tile_done); end
      if (memory_write_ready) begin
        void'(exp_q.pop_front());
        beats++;
      end else begin
        stall++;
      end
      tick();
      cyc++;
    end
    memory_write_ready = 1'b1;
    n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL bp_cycles got %0d want 7", cyc); end
    n_cmp++; if (tile_done !== 1'b1) begin n_bad++; $display("FAIL bp_done got %b want 1", tile_done); end
    tick();
    exp_q.delete();
  endtask

  task automatic test_ordering();
    tile_t ta, tb, tc;
    beat_t b;
    ta = mk_tile(100);
    tb = mk_tile(200);
    tc = mk_tile(300);
    result_data = ta;
    result_valid = 1'b1;
    instruction_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (result_ready !== 1'b0) begin n_bad++; $display("FAIL ord_rready_idle%0d got %b want 0", k, result_ready); end
      tick();
    end
    result_data = tb;
    push_tile(64'd300, 64'd16, tb, 4);
    address_input = 64'd300;
    stride_input = 13'd16;
    instruction_valid = 1'b1;
    tick();
    address_input = 64'd500;
    stride_input = 13'd5;
    n_cmp++; if (result_ready !== 1'b1) begin n_bad++; $display("FAIL ord_rready got %b want 1", result_ready); end
    n_cmp++; if (instruction_ready !== 1'b0) begin n_bad++; $display("FAIL ord_iready_wait got %b want 0", instruction_ready); end
    tick();
    result_data = tc;
    for (int k = 0; k < 4; k++) begin
      b = exp_q.pop_front();
      n_cmp++; if (instruction_ready !== 1'b0) begin n_bad++; $display("FAIL ord_iready_wr%0d got %b want 0", k, instruction_ready); end
      n_cmp++; if (memory_write_address !== b.addr) begin n_bad++; $display("FAIL ord_addr%0d got %0d want %0d", k, memory_write_address, b.addr); end
      n_cmp++; if (memory_write_bus !== b.data) begin n_bad++; $display("FAIL ord_bus%0d got %h want %h", k, memory_write_bus, b.data); end
      tick();
    end
    n_cmp++; if (tile_done !== 1'b1) begin n_bad++; $display("FAIL ord_done1 got %b want 1", tile_done); end
    n_cmp++; if (instruction_ready !== 1'b1) begin n_bad++; $display("FAIL ord_iready_done got %b want 1", instruction_ready); end
    push_tile(64'd500, 64'd5, tc, 4);
    tick();
    instruction_valid = 1'b0;
    n_cmp++; if (result_ready !== 1'b1) begin n_bad++; $display("FAIL ord_rready2 got %b want 1", result_ready); end
    tick();
    result_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b = exp_q.pop_front();
      n_cmp++; if (memory_write_address !== b.addr) begin n_bad++; $display("FAIL ord2_addr%0d got %0d want %0d", k, memory_write_address, b.addr); end
      n_cmp++; if (memory_write_bus !== b.data) begin n_bad++; $display("FAIL ord2_bus%0d got %h want %h", k, memory_write_bus, b.data); end
      tick();
    end
    n_cmp++; if (tile_done !== 1'b1) begin n_bad++; $display("FAIL ord_done2 got %b want 1", tile_done); end
    tick();
  endtask

  task automatic test_wrap();
    tile_t t;
    beat_t b;
    t = mk_tile(50);
    push_tile(64'hFFFF_FFFF_FFFF_FFFC, 64'd8, t, 4);
    address_input = 64'hFFFF_FFFF_FFFF_FFFC;
    stride_input = 13'd8;
    result_data = t;
    result_valid = 1'b1;
    instruction_valid = 1'b1;
    tick();
    instruction_valid = 1'b0;
    tick();
    result_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b = exp_q.pop_front();
      n_cmp++; if (memory_write_address !== b.addr) begin n_bad++; $display("FAIL wrap_addr%0d got %h want %h", k, memory_write_address, b.addr); end
      n_cmp++; if (memory_write_bus !== b.data) begin n_bad++; $display("FAIL wrap_bus%0d got %h want %h", k, memory_write_bus, b.data); end
      tick();
    end
    n_cmp++; if (tile_done !== 1'b1) begin n_bad++; $display("FAIL wrap_done got %b want 1", tile_done); end
    tick();
  endtask

  task automatic test_reset_mid();
    tile_t t;
    beat_t b;
    t = mk_tile(7);
    push_tile(64'd900, 64'd8, t, 4);
    address_input = 64'd900;
    stride_input = 13'd8;
    result_data = t;
    result_valid = 1'b1;
    instruction_valid = 1'b1;
    tick();
    instruction_valid = 1'b0;
    tick();
    result_valid = 1'b0;
    b = exp_q.pop_front();
    n_cmp++; if (memory_write_address !== b.addr) begin n_bad++; $display("FAIL rm_addr0 got %0d want %0d", memory_write_address, b.addr); end
    tick();
    exp_q.delete();
    reset = 1'b0;
    #1;
    n_cmp++; if (memory_write_valid !== 1'b0) begin n_bad++; $display("FAIL rm_mv got %b want 0", memory_write_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (tile_done !== 1'b0) begin n_bad++; $display("FAIL rm_done%0d got %b want 0", k, tile_done); end
    end
    reset = 1'b1;
    tick();
    n_cmp++; if (instruction_ready !== 1'b1) begin n_bad++; $display("FAIL rm_iready got %b want 1", instruction_ready); end
    n_cmp++; if (tile_done !== 1'b0) begin n_bad++; $display("FAIL rm_done_after got %b want 0", tile_done); end
    t = mk_tile(20);
    push_tile(64'd40, 64'd0, t, 4);
    address_input = 64'd40;
    stride_input = 13'd0;
    result_data = t;
    result_valid = 1'b1;
    instruction_valid = 1'b1;
    tick();
    instruction_valid = 1'b0;
    tick();
    result_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b = exp_q.pop_front();
      n_cmp++; if (memory_write_address !== b.addr) begin n_bad++; $display("FAIL rm2_addr%0d got %0d want %0d", k, memory_write_address, b.addr); end
      n_cmp++; if (memory_write_bus !== b.data) begin n_bad++; $display("FAIL rm2_bus%0d got %h want %h", k, memory_write_bus, b.data); end
      tick();
    end
    n_cmp++; if (tile_done !== 1'b1) begin n_bad++; $display("FAIL rm2_done got %b want 1", tile_done); end
    tick();
  endtask

  task automatic test_p2();
    tile_t t;
    beat_t b;
    t = mk_tile(0);
    push_tile(64'd0, 64'd4, t, 2);
    b_addr_in = 64'd0;
    b_stride = 13'd4;
    b_rdata = t;
    b_rv = 1'b1;
    b_mr = 1'b1;
    b_iv = 1'b1;
    tick();
    b_iv = 1'b0;
    tick();
    b_rv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b = exp_q.pop_front();
      n_cmp++; if (b_mv !== 1'b1) begin n_bad++; $display("FAIL p2_mv%0d got %b want 1", k, b_mv); end
      n_cmp++; if (b_maddr !== b.addr) begin n_bad++; $display("FAIL p2_addr%0d got %0d want %0d", k, b_maddr, b.addr); end
      n_cmp++; if (b_bus !== b.data[1:0]) begin n_bad++; $display("FAIL p2_bus%0d got %h want %h", k, b_bus, b.data[1:0]); end
      tick();
    end
    n_cmp++; if (b_done !== 1'b1) begin n_bad++; $display("FAIL p2_done got %b want 1", b_done); end
    n_cmp++; if (b_mv !== 1'b0) begin n_bad++; $display("FAIL p2_mv_end got %b want 0", b_mv); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    instruction_valid = 1'b0;
    address_input = '0;
    stride_input = '0;
    result_valid = 1'b0;
    result_data = '0;
    memory_write_ready = 1'b1;
    b_iv = 1'b0;
    b_addr_in = '0;
    b_stride = '0;
    b_rv = 1'b0;
    b_rdata = '0;
    b_mr = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_ordering();
    test_wrap();
    test_reset_mid();
    test_p2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/output_memory_writer.md
# output_memory_writer

Responder end of the controller's C-address channel: accepts a C tile base address and row stride from the controller, captures one N×N result tile from a sum-stationary processor, and writes it to output memory as PARALLEL_DATA_STREAMING_SIZE-wide beats. One instance sits per processor. The controller counts completions via `tile_done` and re-arms the writer with a new address whenever `instruction_ready` is high.

## Interface
- DATA_WIDTH, 8: operand width (documentation only).
- N, 4: tile edge; tile is N×N results.
- MULTIPLY_DATA_WIDTH, 2*DATA_WIDTH: product width.
- ACCUM_DATA_WIDTH, 16: extra accumulation bits.
- OUT_WIDTH, MULTIPLY_DATA_WIDTH+ACCUM_DATA_WIDTH: result element width.
- MAX_MATRIX_LENGTH, 4096: largest matrix edge.
- STRIDE_BITS, $clog2(MAX_MATRIX_LENGTH+1): stride width.
- MEMORY_ADDRESS_BITS, 64: address width, element-granular.
- PARALLEL_DATA_STREAMING_SIZE (P), 4: elements per memory write beat. N % P == 0 required; elaboration error otherwise.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- instruction_valid  in  1  controller offers address/stride.
- instruction_ready  out  1  writer idle, can take an instruction.
- address_input  in  MEMORY_ADDRESS_BITS  C tile base (element 0,0).
- stride_input  in  STRIDE_BITS  row-to-row address distance (matrix length).
- result_valid  in  1  processor tile available.
- result_ready  out  1  writer accepts tile.
- result_data  in  OUT_WIDTH × [N][N]  tile, [row][col].
- memory_write_valid  out  1  write beat presented.
- memory_write_ready  in  1  memory accepts beat.
- memory_write_address  out  MEMORY_ADDRESS_BITS  beat address.
- memory_write_bus  out  OUT_WIDTH × [P]  beat data; lane p = column chunk*P+p.
- tile_done  out  1  one-cycle pulse after final beat accepted.

## Operation
- States: IDLE, WAIT_DATA, WRITE. `instruction_ready` = (state==IDLE); `result_ready` = (state==WAIT_DATA); `memory_write_valid` = (state==WRITE).
- IDLE: instruction handshake latches base and stride, sets row_base=base, row=0, chunk=0 → WAIT_DATA.
- WAIT_DATA: result handshake latches full tile into local register → WRITE.
- WRITE: beat address = row_base + chunk*P; data = tile[row][chunk*P +: P]. On write handshake: chunk++; at chunk = N/P−1, chunk=0, row++, row_base += stride. Handshake on last beat (row N−1, last chunk) → IDLE, tile_done=1 next cycle.
- Beats in row-major order, N*N/P beats per tile. Data passed unmodified, no saturation.
- Address arithmetic modulo 2^MEMORY_ADDRESS_BITS; stride zero-extended. No multiplier: row_base accumulates.
- instruction_valid outside IDLE and result_valid outside WAIT_DATA are ignored (not consumed). Stride 0 legal: all rows hit same addresses.

## Timing
- Reset (asynchronous): state=IDLE, counters/registers 0, tile_done=0, memory_write_valid=0, result_ready=0; instruction_ready=1 (decoded from IDLE). Reset mid-tile discards the tile, drops memory_write_valid immediately, no tile_done.
- Instruction handshake cycle t → result_ready=1 at t+1.
- Result handshake cycle u → memory_write_valid=1 with beat 0 at u+1.
- Once valid, address and bus held stable until memory_write_ready; valid never retracted mid-tile. Full-throughput: one beat/cycle.
- Last beat handshake cycle v → tile_done=1 and instruction_ready=1 at v+1; a new instruction may be accepted in v+1.
- Minimum instruction-to-done latency: N*N/P + 2 cycles.

## Test plan
- Defaults, base=100, stride=8, tile[r][c]=4r+c+1, memory_write_ready=1, result_valid=1: instruction at t, result at t+1, beats t+2..t+5 at addresses 100,108,116,124 with data {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}; tile_done at t+6 only.
- Backpressure: memory_write_ready=0 for 3 cycles during beat 1 → address 108 and data {5,6,7,8} held stable 4 cycles; exactly 4 beats total; tile_done delayed by 3.
- P=2, base=0, stride=4 → 8 beats at addresses 0,2,4,6,8,10,12,14, lane data per row-major chunk.
- Ordering: result_valid high before instruction → result_ready=0, no capture until after instruction handshake; instruction_valid held during WRITE → instruction_ready=0, second instruction accepted the cycle tile_done asserts.
- Wrap: base=2^64−4, stride=8 → addresses 2^64−4, 4, 12, 20.
- Reset asserted after beat 0 accepted → memory_write_valid=0 same cycle, no tile_done; after release instruction_ready=1, fresh tile writes correctly from beat 0.
